// File: rtl/led_cube_pkg.sv
// Shared types and constants for the LED matrix pattern path.
// Holds row width, pattern index width, scan states and index wrap helper.
package led_cube_pkg;

    localparam int ROWS          = 10;
    localparam int COLS          = 10;
    localparam int PATTERN_IDX_W = 4;

    typedef logic [COLS-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BLANK,
        SHOW
    } scan_state_e;

    // Step to the next pattern, wrapping from the last index to the first.
    function automatic logic [PATTERN_IDX_W-1:0] next_pattern(
        input logic [PATTERN_IDX_W-1:0] idx,
        input int                       first,
        input int                       num
    );
        if (int'(idx) >= first + num - 1)
            return PATTERN_IDX_W'(first);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/led_row_scanner_scan_timer.sv
// Loadable dwell down-counter for the row scanner.
// done pulses for one clock on the last clock of a loaded interval.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;
    logic         running;

    assign done = running && (count == '0);

    // Count down a loaded interval; idle once it expires.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= value;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0)
                running <= 1'b0;
            else
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/led_row_scanner.sv
// Snapshots a stored pattern and time-multiplexes its rows onto the matrix.
// Optional anti-ghost blanking between rows is enabled by SCAN_BLANK_EN.
module led_row_scanner
    import led_cube_pkg::*;
#(
    parameter int ROW_CYCLES         = 1000,
    parameter int BLANK_CYCLES       = 4,
    parameter int FRAMES_PER_PATTERN = 50,
    parameter int FIRST_PATTERN      = 1,
    parameter int NUM_PATTERNS       = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [COLS-1:0]          patternRow [ROWS-1:0],
    output logic [PATTERN_IDX_W-1:0] patternIndex,
    output logic [ROWS-1:0]          rowSel,
    output logic [COLS-1:0]          colData,
    output logic                     frameStart
);

    localparam int MAX_DWELL =
        (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
    localparam int TW  = $clog2(MAX_DWELL + 1);
    localparam int FCW = $clog2(FRAMES_PER_PATTERN + 1);

    localparam logic [TW-1:0] LOAD_VAL  = TW'(1);
    localparam logic [TW-1:0] SHOW_VAL  = TW'(ROW_CYCLES - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [TW-1:0] BLANK_VAL = TW'(BLANK_CYCLES - 1);
`endif

    scan_state_e state;
    scan_state_e state_n;

    logic [3:0]               row;
    logic [3:0]               row_n;
    logic [FCW-1:0]           frame_cnt;
    logic [FCW-1:0]           frame_cnt_n;
    logic [PATTERN_IDX_W-1:0] idx_n;
    logic                     frame_start_n;
    logic                     capture;

    logic                     tmr_clear;
    logic                     tmr_load;
    logic [TW-1:0]            tmr_value;
    logic                     tmr_done;

    row_t frame_buf [ROWS];

    scan_timer #(
        .W(TW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(tmr_clear),
        .load (tmr_load),
        .value(tmr_value),
        .done (tmr_done)
    );

    // Next-state, row/frame bookkeeping and dwell timer control.
    always_comb begin
        state_n       = state;
        row_n         = row;
        frame_cnt_n   = frame_cnt;
        idx_n         = patternIndex;
        frame_start_n = 1'b0;
        capture       = 1'b0;
        tmr_clear     = 1'b0;
        tmr_load      = 1'b0;
        tmr_value     = '0;

        if (!enable) begin
            state_n     = IDLE;
            row_n       = '0;
            frame_cnt_n = '0;
            tmr_clear   = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n   = LOAD;
                    tmr_load  = 1'b1;
                    tmr_value = LOAD_VAL;
                end
                LOAD: begin
                    if (tmr_done) begin
                        capture     = 1'b1;
                        row_n       = '0;
                        frame_cnt_n = '0;
                        tmr_load    = 1'b1;
`ifdef SCAN_BLANK_EN
                        state_n     = BLANK;
                        tmr_value   = BLANK_VAL;
`else
                        state_n     = SHOW;
                        tmr_value   = SHOW_VAL;
`endif
                    end else begin
                        // Pulse lands on the clock the snapshot is taken.
                        frame_start_n = 1'b1;
                    end
                end
                BLANK: begin
                    if (tmr_done) begin
                        state_n   = SHOW;
                        tmr_load  = 1'b1;
                        tmr_value = SHOW_VAL;
                    end
                end
                SHOW: begin
                    if (tmr_done) begin
                        tmr_load = 1'b1;
`ifdef SCAN_BLANK_EN
                        state_n   = BLANK;
                        tmr_value = BLANK_VAL;
`else
                        state_n   = SHOW;
                        tmr_value = SHOW_VAL;
`endif
                        if (row < 4'd9) begin
                            row_n = row + 4'd1;
                        end else if (32'(frame_cnt) + 32'd1 <
                                     32'(FRAMES_PER_PATTERN)) begin
                            row_n       = '0;
                            frame_cnt_n = frame_cnt + 1'b1;
                        end else begin
                            row_n       = '0;
                            frame_cnt_n = '0;
                            idx_n       = next_pattern(patternIndex,
                                                       FIRST_PATTERN,
                                                       NUM_PATTERNS);
                            state_n     = LOAD;
                            tmr_value   = LOAD_VAL;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Sequencer state, counters and pattern select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            row          <= '0;
            frame_cnt    <= '0;
            patternIndex <= PATTERN_IDX_W'(FIRST_PATTERN);
        end else begin
            state        <= state_n;
            row          <= row_n;
            frame_cnt    <= frame_cnt_n;
            patternIndex <= idx_n;
        end
    end

    // Frame buffer only changes on the final LOAD clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                frame_buf[r] <= '0;
        end else if (capture) begin
            for (int r = 0; r < ROWS; r++)
                frame_buf[r] <= patternRow[r];
        end
    end

    // Registered matrix drive, aligned with the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            rowSel     <= '0;
            colData    <= '0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= frame_start_n;
            if (state_n == SHOW) begin
                rowSel  <= ROWS'(1) << row_n;
                colData <= capture ? patternRow[row_n]
                                   : frame_buf[row_n];
            end else begin
                rowSel  <= '0;
                colData <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_row_scanner.sv
// Self-checking bench for led_row_scanner against a timeline model.
// Model derives each output from clocks elapsed since the last LOAD start.
module tb_led_row_scanner;

    localparam int RC    = 3;
    localparam int BC    = 2;
    localparam int FPP   = 2;
    localparam int FIRST = 1;
    localparam int NUMP  = 5;
`ifdef SCAN_BLANK_EN
    localparam int B = BC;
`else
    localparam int B = 0;
`endif
    localparam int P     = B + RC;
    localparam int FRAME = 10 * P;
    localparam int EP    = 2 + FPP * FRAME;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [9:0] pattern_row [9:0];
    logic [3:0] pattern_index;
    logic [9:0] row_sel;
    logic [9:0] col_data;
    logic       frame_start;

    logic [9:0] mem [16][10];
    logic [9:0] fbuf [10];
    int         t = 0;
    int         m_idx = FIRST;
    int         errors = 0;
    int         checks = 0;
    int         hold_idx;

    led_row_scanner #(
        .ROW_CYCLES        (RC),
        .BLANK_CYCLES      (BC),
        .FRAMES_PER_PATTERN(FPP),
        .FIRST_PATTERN     (FIRST),
        .NUM_PATTERNS      (NUMP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .patternRow  (pattern_row),
        .patternIndex(pattern_index),
        .rowSel      (row_sel),
        .colData     (col_data),
        .frameStart  (frame_start)
    );

    always #5 clk = ~clk;

    // Pattern storage with one clock of read latency.
    always @(posedge clk)
        for (int r = 0; r < 10; r++)
            pattern_row[r] <= mem[pattern_index][r];

    function automatic int lit_row(input int tt);
        int w;
        if (tt < 3) return -1;
        w = (tt - 3) % FRAME;
        if ((w % P) < B) return -1;
        return w / P;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d idx=%0d",
                   tag, obs, exp, t, m_idx);
        end
    endtask

    task automatic check_outputs();
        logic [9:0] er;
        logic [9:0] ec;
        int         r;
        r  = lit_row(t);
        er = (r >= 0) ? (10'b1 << r) : 10'b0;
        ec = (r >= 0) ? fbuf[r] : 10'b0;
        chk("rowSel", 32'(row_sel), 32'(er));
        chk("colData", 32'(col_data), 32'(ec));
        chk("frameStart", 32'(frame_start), 32'(t == 2));
        chk("patternIndex", 32'(pattern_index), 32'(m_idx));
        chk("onehot", 32'($countones(row_sel) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            t     = 0;
            m_idx = FIRST;
        end else if (!enable) begin
            t = 0;
        end else if (t == 0) begin
            t = 1;
        end else if (t == EP) begin
            t     = 1;
            m_idx = (m_idx == FIRST + NUMP - 1) ? FIRST : m_idx + 1;
        end else begin
            if (t == 2)
                for (int r = 0; r < 10; r++)
                    fbuf[r] = mem[m_idx][r];
            t++;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        for (int p = 0; p < 16; p++)
            for (int r = 0; r < 10; r++)
                mem[p][r] = 10'($urandom);
        mem[1][0] = 10'b0110000110;
        mem[1][9] = 10'b0001111000;
        for (int r = 0; r < 10; r++)
            fbuf[r] = '0;

        // Reset held for three clocks.
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_idx", 32'(pattern_index), 32'd1);
        rst = 1'b0;
        tick();

        // First frame of pattern 1.
        enable = 1'b1;
        tick();
        chk("clk1_fs", 32'(frame_start), 32'd0);
        tick();
        chk("clk2_fs", 32'(frame_start), 32'd1);
        for (int i = 0; i < B; i++) begin
            tick();
            chk("blank_dark", 32'(row_sel), 32'd0);
        end
        for (int i = 0; i < RC; i++) begin
            tick();
            chk("row0_sel", 32'(row_sel), 32'h001);
            chk("row0_col", 32'(col_data), 32'h186);
        end
        for (int i = 0; i < 200 && lit_row(t) != 9; i++) tick();
        chk("row9_col", 32'(col_data), 32'h078);
        chk("row9_t", 32'(t), 32'(3 + 9 * P + B));

        // Free run through the full pattern cycle.
        for (int i = 0; i < 3 * EP && m_idx != 2; i++) tick();
        chk("adv_to_2", 32'(pattern_index), 32'd2);
        chk("adv_dark", 32'(row_sel), 32'd0);
        for (int i = 0; i < 5 * EP && m_idx != 5; i++) tick();
        chk("reach_5", 32'(pattern_index), 32'd5);
        for (int i = 0; i < 2 * EP && m_idx != 1; i++) tick();
        chk("wrap_to_1", 32'(pattern_index), 32'd1);

        // Storage rewritten mid-frame must not tear the display.
        for (int i = 0; i < EP && t != 20; i++) tick();
        for (int r = 0; r < 10; r++)
            mem[m_idx][r] = ~fbuf[r] ^ 10'($urandom_range(0, 3));
        for (int i = 0; i < EP && t != EP; i++) tick();
        chk("notear_end", 32'(t), 32'(EP));

        // Disable during row 4, then resume on the same pattern.
        for (int i = 0; i < 2 * EP && lit_row(t) != 4; i++) tick();
        chk("at_row4", 32'(row_sel), 32'h010);
        hold_idx = m_idx;
        enable = 1'b0;
        tick();
        chk("dis_sel", 32'(row_sel), 32'd0);
        chk("dis_col", 32'(col_data), 32'd0);
        repeat (3) tick();
        enable = 1'b1;
        tick();
        chk("reen_idx", 32'(pattern_index), 32'(hold_idx));
        for (int i = 0; i < 20 && lit_row(t) != 0; i++) tick();
        chk("reen_row0", 32'(row_sel), 32'h001);

        // Reset mid-SHOW of pattern 3.
        for (int i = 0; i < 6 * EP && !(m_idx == 3 && lit_row(t) >= 0); i++)
            tick();
        chk("at_p3", 32'(pattern_index), 32'd3);
        rst = 1'b1;
        tick();
        chk("rst_sel", 32'(row_sel), 32'd0);
        chk("rst_col", 32'(col_data), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_p1", 32'(pattern_index), 32'd1);
        rst = 1'b0;
        repeat (FRAME + 10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_row_scanner.md
# led_row_scanner

Consumer side of the pattern-storage interface. Drives `patternIndex` to select a pattern, waits for the storage block's registered read, snapshots all 10 rows into a frame buffer, then time-multiplexes them onto the physical LED matrix one row at a time. It advances to the next pattern after a fixed number of frames.

## Interface
Parameters:
- `ROW_CYCLES`, default 1000: clocks each row is lit (≥1).
- `BLANK_CYCLES`, default 4: dark clocks before each row (anti-ghosting, ≥1).
- `FRAMES_PER_PATTERN`, default 50: full 10-row frames shown per pattern (≥1).
- `FIRST_PATTERN`, default 1: lowest pattern index used.
- `NUM_PATTERNS`, default 5: patterns cycled, `FIRST_PATTERN`..`FIRST_PATTERN+NUM_PATTERNS-1` (≤15 total).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run scanning; low forces dark.
- `patternRow` in [9:0] x10 (unpacked `[9:0]`): rows from pattern storage, valid 1 clock after `patternIndex` changes.
- `patternIndex` out 4: pattern select to storage.
- `rowSel` out 10: one-hot row drive, bit r = row r; all-zero = dark.
- `colData` out 10: column drive for the selected row; bit 9 = leftmost column.
- `frameStart` out 1: one-clock pulse when a frame buffer snapshot is taken.

## Operation
- States: IDLE, LOAD, BLANK, SHOW.
- IDLE: `rowSel`=0, `colData`=0. If `enable`=1, go to LOAD next cycle.
- LOAD: lasts exactly 2 clocks, covering the storage read register plus one cycle of margin. On the last LOAD clock:
  - capture `frameBuf[r] <= patternRow[r]` for r=0..9;
  - assert `frameStart`;
  - clear `row`=0 and `frameCnt`=0 only when entering from IDLE or after a pattern advance;
  - next state BLANK.
- BLANK: `BLANK_CYCLES` clocks, `rowSel`=0, `colData`=0, then SHOW.
- SHOW: `ROW_CYCLES` clocks, `rowSel`=1<<row, `colData`=`frameBuf[row]`. At the end of SHOW:
  - row<9: row+1, go to BLANK.
  - row=9, `frameCnt`+1<`FRAMES_PER_PATTERN`: `frameCnt`+1, row=0, go to BLANK. The buffer is reused and no LOAD occurs.
  - row=9, final frame: advance `patternIndex` (from the last index, wrap to `FIRST_PATTERN`), go to LOAD.
- `frameBuf` changes only in LOAD. `patternRow` changes mid-frame never tear the display.
- `enable`=0 in any state other than IDLE: next clock is IDLE.
  - Outputs go dark on that clock.
  - `row`, `frameCnt` and the dwell timer clear.
  - `patternIndex` is held.
  - Re-enable restarts at LOAD with the same index.
- `rowSel` is never multi-hot. `rowSel` and `colData` are registered outputs.

## Timing
- Reset values: `patternIndex`=`FIRST_PATTERN`, `rowSel`=0, `colData`=0, `frameStart`=0, state IDLE, `frameBuf`=0.
- `rst` overrides `enable` and applies at the next clock edge from any state, including mid-SHOW and mid-LOAD.
- `enable` rising from IDLE: LOAD occupies clocks 1–2 and `frameStart` is high on clock 2. The first lit row is visible `BLANK_CYCLES` clocks later.
- Frame period: 10×(`BLANK_CYCLES`+`ROW_CYCLES`) clocks. Each pattern change inserts 2 extra LOAD clocks, which are dark.
- Dwell timer width is ceil(log2(max(`ROW_CYCLES`,`BLANK_CYCLES`)+1)). `frameCnt` width is ceil(log2(`FRAMES_PER_PATTERN`+1)).

## Configuration
- `SCAN_BLANK_EN` defined: BLANK state is present as described.
- `SCAN_BLANK_EN` undefined:
  - BLANK is removed and `BLANK_CYCLES` is ignored.
  - LOAD goes straight to SHOW, and SHOW goes to SHOW of the next row.
  - `rowSel` moves one-hot to one-hot with no dark clock.
  - Frame period is 10×`ROW_CYCLES`.

## Structure
- Shared package `led_cube_pkg`:
  - `ROWS`=10, `COLS`=10, `PATTERN_IDX_W`=4;
  - `row_t` (logic [9:0]);
  - scan state enum `scan_state_e` {IDLE, LOAD, BLANK, SHOW}.
- One sub-module `scan_timer`: loadable down-counter with `load`, `value` and a one-clock `done` pulse. It is used for the BLANK, SHOW and LOAD dwell.

## Test plan
Bench parameters: `ROW_CYCLES`=3, `BLANK_CYCLES`=2, `FRAMES_PER_PATTERN`=2, `FIRST_PATTERN`=1, `NUM_PATTERNS`=5, with a 1-clock-latency storage model.

1. Reset held 3 clocks → `rowSel`=0, `colData`=0, `frameStart`=0, `patternIndex`=1.
2. `enable`=1 → `frameStart` pulses on clock 2, clocks 3–4 dark, clocks 5–7 `rowSel`=10'b0000000001 and `colData`=10'b0110000110. Row 9 shows 10'b0001111000. Frame period is 50 clocks.
3. Free run → `patternIndex` goes 1→2 after 2 frames, then 5→1. Each change is followed by 2 dark LOAD clocks and a `frameStart` pulse.
4. Storage model rows changed mid-frame → `colData` keeps the old buffer until the next LOAD.
5. `enable`=0 during row-4 SHOW → next clock `rowSel`=0 and `colData`=0. Re-enable → LOAD, then row 0 of the same `patternIndex`.
6. `rst` pulsed mid-SHOW of pattern 3 → next clock all outputs are at reset values with `patternIndex`=1. Without `SCAN_BLANK_EN`, `rowSel` is never zero between rows and the frame period is 30 clocks.
